// File: rtl/codec_tx.sv
// codec_tx: CS4272 serial audio transmitter.
// Generates MCLK/SCLK/LRCLK from a free-running frame counter, sequences the
// codec out of reset, double-buffers one stereo pair and shifts it out
// left-justified, MSB first, once per 1024-clk frame.
//
// state | meaning
// ------+-----------------------------------------------------------
// HOLD  | codec held in reset (RSTn=0), silence shifted out
// MUTE  | codec released, one frame of silence while it wakes up
// RUN   | every frame loads the held pair, or repeats the last one
module codec_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lft_in,
    input  logic [15:0] rht_in,
    input  logic        vld,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRCLK,
    output logic        SDin,
    output logic        RSTn,
    output logic        frm_strt,
    output logic        underrun,
    output logic        overrun
);

    typedef enum logic [1:0] {HOLD, MUTE, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  cnt;
    logic [9:0]  cnt_nxt;
    logic        lrclk_q;
    logic        rstn_q;
    logic [31:0] hold;
    logic [31:0] last;
    logic [31:0] sh;
    logic        full;
    logic        load;
    logic        shift;
    logic        run_load;
    logic        consume;

    assign cnt_nxt = cnt + 10'd1;
    assign load    = (cnt == 10'd1023);
    assign shift   = (cnt[4:0] == 5'd31) && !load;
    assign consume = run_load && full;

    // LRCLK and RSTn get their own flops so every codec pin comes straight
    // from a register with no gating in front of it.
    assign MCLK  = cnt[1];
    assign SCLK  = cnt[4];
    assign LRCLK = lrclk_q;
    assign SDin  = sh[31];
    assign RSTn  = rstn_q;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next state; the MUTE->RUN edge is already a data load.
    always_comb begin
        state_nxt = state;
        run_load  = 1'b0;
        if (load) begin
            case (state)
                HOLD: state_nxt = MUTE;
                MUTE: begin
                    state_nxt = RUN;
                    run_load  = 1'b1;
                end
                RUN:  run_load = 1'b1;
                default: state_nxt = HOLD;
            endcase
        end
    end

    // Frame counter and registered codec clock/reset pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            lrclk_q <= 1'b1;
            rstn_q  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            lrclk_q <= ~cnt_nxt[9];
            rstn_q  <= (state_nxt != HOLD);
        end
    end

    // Transmit shifter: load on frame boundary, shift once per bit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            last <= '0;
        end else if (load) begin
            if (!run_load) begin
                sh <= '0;
            end else if (full) begin
                sh   <= hold;
                last <= hold;
            end else begin
                sh <= last;
            end
        end else if (shift) begin
            sh <= {sh[30:0], 1'b0};
        end
    end

    // Holding register: a write on the load edge lands after the load
    // has taken the old contents, so it stays full for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            full <= 1'b0;
        end else if (vld) begin
            hold <= {lft_in, rht_in};
            full <= 1'b1;
        end else if (consume) begin
            full <= 1'b0;
        end
    end

    // Status pulses, one clk wide after the triggering edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_strt <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            frm_strt <= load;
            underrun <= run_load && !full;
            overrun  <= vld && full && !consume;
        end
    end

endmodule
